// File: rtl/operand_fetch.sv
// Decode / operand-fetch stage.
//
// Pulls rs1/rs2/rd out of the fetched instruction and drives the register
// file read addresses. Each source operand is resolved against the EX, MEM
// and WB results so the ALU sees the newest value. An EX load that writes a
// register this instruction reads has no value yet, so the instruction is
// held back for a cycle and a bubble goes downstream. The register file has
// no write-to-read bypass, which is why WB is part of the forwarding chain.
// Resolved operands are captured into the ID/EX register under a
// valid/ready handshake.
//
// Ports
//   clock, reset_n                 clock, async active-low reset
//   flush                          sync redirect; drops ID/EX and the input
//   in_valid/in_ready/in_pc/in_instr     upstream handshake + payload
//   rs1_address/rs2_address        register-file read addresses (comb)
//   rs1_data/rs2_data              register-file read data
//   ex_*/mem_*/wb_*                downstream destination info for forwarding
//   out_valid/out_ready/out_*      ID/EX register handshake + payload
//   stall_count                    saturating count of load-use stall cycles

// Resolves one source operand and flags a load-use conflict on it.
module operand_resolve #(
  parameter int XLEN = 32
) (
  input  logic [4:0]      src,
  input  logic            used,
  input  logic [XLEN-1:0] rf_data,
  input  logic            ex_valid,
  input  logic [4:0]      ex_rd,
  input  logic            ex_writes,
  input  logic            ex_is_load,
  input  logic [XLEN-1:0] ex_result,
  input  logic            mem_valid,
  input  logic [4:0]      mem_rd,
  input  logic            mem_writes,
  input  logic [XLEN-1:0] mem_result,
  input  logic            wb_write_enable,
  input  logic [4:0]      wb_rd_address,
  input  logic [XLEN-1:0] wb_rd_data,
  output logic [XLEN-1:0] value,
  output logic            load_hit
);
  // Newest producer wins. A load in EX has no data yet, so it is skipped
  // here; the hazard below keeps the instruction from being accepted.
  always_comb begin
    value = rf_data;
    if (src == 5'd0)
      value = '0;
    else if (ex_valid && ex_writes && !ex_is_load && ex_rd == src)
      value = ex_result;
    else if (mem_valid && mem_writes && mem_rd == src)
      value = mem_result;
    else if (wb_write_enable && wb_rd_address == src)
      value = wb_rd_data;
  end

  assign load_hit = used && ex_valid && ex_writes && ex_is_load &&
                    (ex_rd != 5'd0) && (ex_rd == src);
endmodule

module operand_fetch #(
  parameter int XLEN        = 32,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic                   flush,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [XLEN-1:0]        in_pc,
  input  logic [31:0]            in_instr,
  output logic [4:0]             rs1_address,
  output logic [4:0]             rs2_address,
  input  logic [XLEN-1:0]        rs1_data,
  input  logic [XLEN-1:0]        rs2_data,
  input  logic                   ex_valid,
  input  logic [4:0]             ex_rd,
  input  logic                   ex_writes,
  input  logic                   ex_is_load,
  input  logic [XLEN-1:0]        ex_result,
  input  logic                   mem_valid,
  input  logic [4:0]             mem_rd,
  input  logic                   mem_writes,
  input  logic [XLEN-1:0]        mem_result,
  input  logic                   wb_write_enable,
  input  logic [4:0]             wb_rd_address,
  input  logic [XLEN-1:0]        wb_rd_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [XLEN-1:0]        out_pc,
  output logic [31:0]            out_instr,
  output logic [4:0]             out_rd,
  output logic [XLEN-1:0]        out_rs1_value,
  output logic [XLEN-1:0]        out_rs2_value,
  output logic [STALL_CNT_W-1:0] stall_count
);
  localparam int NUM_SRC = 2;

  logic [NUM_SRC-1:0][4:0]      src_addr;
  logic [NUM_SRC-1:0]           src_used;
  logic [NUM_SRC-1:0][XLEN-1:0] src_rf;
  logic [NUM_SRC-1:0][XLEN-1:0] src_value;
  logic [NUM_SRC-1:0]           src_load_hit;
  logic                         hazard, advance, accept;

  assign src_addr[0] = in_instr[19:15];
  assign src_addr[1] = in_instr[24:20];
  assign src_rf[0]   = rs1_data;
  assign src_rf[1]   = rs2_data;
  assign rs1_address = src_addr[0];
  assign rs2_address = src_addr[1];

  // Which register fields are real sources. Unknown opcodes are treated as
  // reading both, which can only cost a stall, never a wrong operand.
  always_comb begin
    src_used = 2'b11;
    case (in_instr[6:0])
      7'b0110111, 7'b0010111, 7'b1101111:             src_used = 2'b00;
      7'b1100111, 7'b0000011, 7'b0010011, 7'b1110011: src_used = 2'b01;
      default:                                        src_used = 2'b11;
    endcase
  end

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    operand_resolve #(.XLEN(XLEN)) u_res (
      .src             (src_addr[g]),
      .used            (src_used[g]),
      .rf_data         (src_rf[g]),
      .ex_valid        (ex_valid),
      .ex_rd           (ex_rd),
      .ex_writes       (ex_writes),
      .ex_is_load      (ex_is_load),
      .ex_result       (ex_result),
      .mem_valid       (mem_valid),
      .mem_rd          (mem_rd),
      .mem_writes      (mem_writes),
      .mem_result      (mem_result),
      .wb_write_enable (wb_write_enable),
      .wb_rd_address   (wb_rd_address),
      .wb_rd_data      (wb_rd_data),
      .value           (src_value[g]),
      .load_hit        (src_load_hit[g])
    );
  end

  assign hazard   = in_valid && (|src_load_hit);
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance && !hazard && !flush;
  assign accept   = in_valid && in_ready;

  // ID/EX register. Payload only moves on accept; a bubble or a flush
  // leaves the old payload in place behind a cleared valid.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid     <= 1'b0;
      out_pc        <= '0;
      out_instr     <= '0;
      out_rd        <= '0;
      out_rs1_value <= '0;
      out_rs2_value <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (advance) begin
      out_valid <= in_valid && !hazard;
      if (accept) begin
        out_pc        <= in_pc;
        out_instr     <= in_instr;
        out_rd        <= in_instr[11:7];
        out_rs1_value <= src_value[0];
        out_rs2_value <= src_value[1];
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)
      stall_count <= '0;
    else if (hazard && !flush && stall_count != {STALL_CNT_W{1'b1}})
      stall_count <= stall_count + 1'b1;
  end
endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Decode/operand-fetch stage directly upstream of the register file and ALU.
- Extracts rs1/rs2/rd from the fetched instruction and drives the register-file read addresses.
- Resolves RAW hazards by forwarding from EX/MEM/WB, stalling on load-use, and capturing operands into the ID/EX pipeline register under a valid/ready handshake.
- The register file reads asynchronously and has no internal write-to-read bypass, so this stage owns the WB bypass.

Parameters:
XLEN, 32, data/PC width
STALL_CNT_W, 16, width of saturating load-use stall counter

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous pipeline flush (branch/jump redirect)
in_valid  in  1  fetch presents an instruction
in_ready  out  1  stage accepts instruction this cycle
in_pc  in  XLEN  instruction PC
in_instr  in  32  raw instruction
rs1_address  out  5  register-file read address 1 (combinational from in_instr[19:15])
rs2_address  out  5  register-file read address 2 (combinational from in_instr[24:20])
rs1_data  in  XLEN  register-file read data 1
rs2_data  in  XLEN  register-file read data 2
ex_valid  in  1  EX stage holds a valid instruction
ex_rd  in  5  EX destination register
ex_writes  in  1  EX instruction writes rd
ex_is_load  in  1  EX instruction is a load (result not yet available)
ex_result  in  XLEN  EX ALU result
mem_valid, mem_rd, mem_writes  in  1/5/1  MEM stage destination info
mem_result  in  XLEN  MEM final result (load data included)
wb_write_enable  in  1  WB write strobe (same signal the register file receives)
wb_rd_address  in  5  WB destination
wb_rd_data  in  XLEN  WB data
out_valid  out  1  ID/EX register valid
out_ready  in  1  EX accepts
out_pc  out  XLEN  captured PC
out_instr  out  32  captured instruction
out_rd  out  5  captured instr[11:7]
out_rs1_value  out  XLEN  resolved rs1 operand
out_rs2_value  out  XLEN  resolved rs2 operand
stall_count  out  STALL_CNT_W  number of load-use stall cycles, saturating

Behaviour:
- Reset (async, reset_n=0): out_valid=0; out_pc, out_instr, out_rd, out_rs1_value, out_rs2_value=0; stall_count=0. Reset mid-handshake drops the held instruction with no partial state kept.
- Source usage by opcode in_instr[6:0]:
  - LUI 0110111, AUIPC 0010111, JAL 1101111: no sources.
  - JALR 1100111, LOAD 0000011, OP-IMM 0010011, SYSTEM 1110011: rs1 only.
  - STORE 0100011, BRANCH 1100011, OP 0110011, and any other opcode: rs1 and rs2.
- Operand resolution per source s (combinational, priority order):
  - s==0 gives 0.
  - ex_valid & ex_writes & ex_rd==s & !ex_is_load gives ex_result.
  - mem_valid & mem_writes & mem_rd==s gives mem_result.
  - wb_write_enable & wb_rd_address==s gives wb_rd_data.
  - Otherwise the register-file data.
- Load-use hazard: in_valid & ex_valid & ex_writes & ex_is_load & ex_rd!=0 & ex_rd matches a used source.
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & !flush.
- On each clock edge:
  - flush: out_valid<=0 (highest priority; the instruction presented that cycle is not accepted).
  - else if advance: out_valid<=in_valid & !hazard. On accept, capture out_pc, out_instr, out_rd and the resolved operands. On hazard, a bubble is inserted and payload registers hold their values.
  - else (out_valid & !out_ready): all outputs hold, stable.
- stall_count increments by 1 on each cycle where hazard=1 and flush=0, and saturates at all-ones.
- Latency: 1 cycle from accept to out_valid. Full throughput of 1 instruction per cycle with no hazard and out_ready=1.
- Unused sources never cause a hazard. Forwarding of unused sources is harmless.

Test Plan:
- Reset then in_instr=ADD x3,x1,x2 with rs1_data=5, rs2_data=7, out_ready=1 -> next cycle out_valid=1, out_rs1_value=5, out_rs2_value=7, out_rd=3.
- EX writes x1=0x10, MEM writes x1=0x20, WB writes x1=0x30, regfile x1=0x40; issue ADDI x2,x1,1 -> out_rs1_value=0x10. Drop EX and repeat -> 0x20. Drop MEM -> 0x30.
- EX is LW x5 (ex_is_load=1); issue ADD x6,x5,x0 -> in_ready=0, out_valid=0 for one cycle, stall_count=1. Next cycle ex_valid=0, mem_result=0xABCD -> accepted, out_rs1_value=0xABCD.
- Read of x0 while wb_write_enable=1, wb_rd_address=0, wb_rd_data=0xFFFF -> out_rs1_value=0. LUI with ex_is_load targeting its rd field -> no stall.
- out_valid=1, out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0, outputs unchanged. out_ready=1 -> new instruction captured next edge.
- flush=1 while in_valid=1 and out_valid=1 -> out_valid=0 next cycle, instruction not accepted. Assert reset_n=0 mid-stall -> all outputs 0 immediately.
